// File: rtl/imem_loader_if.sv
// Bus bundle for imem_loader: load request, byte stream and instruction-memory write port.
interface imem_loader_if;
    logic        start;
    logic [15:0] base_addr;
    logic [13:0] word_cnt;
    logic [7:0]  byte_in;
    logic        byte_vld;
    logic        byte_rdy;
    logic [15:0] wr_addr;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, base_addr, word_cnt, byte_in, byte_vld,
        input  byte_rdy, wr_addr, wr_data, wr_en, busy, done, err
    );

    modport slave (
        input  start, base_addr, word_cnt, byte_in, byte_vld,
        output byte_rdy, wr_addr, wr_data, wr_en, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a byte image into 48-bit instruction-memory words (big-endian, 6 bytes per word).
// Optional trailing modulo-256 checksum byte is enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
    parameter int MAX_WORDS = 8192
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef IMEM_LOADER_CHKSUM_EN
        CHECK,
`endif
        DONE
    } state_e;

    localparam logic [14:0] MaxWords = 15'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] addr_q, addr_d;
    logic [13:0] remain_q, remain_d;
    logic [39:0] shift_q, shift_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [47:0] wr_data_q, wr_data_d;
    logic        err_q, err_d;
    logic        byte_rdy;
    logic        xfer;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

`ifdef IMEM_LOADER_CHKSUM_EN
    assign byte_rdy = (state_q == COLLECT) || (state_q == CHECK);
`else
    assign byte_rdy = (state_q == COLLECT);
`endif
    assign xfer = bus.byte_vld && byte_rdy;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        shift_d   = shift_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    if (bus.word_cnt == '0) begin
                        state_d = DONE;
                    end else if ({1'b0, bus.word_cnt} > MaxWords) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d   = bus.base_addr;
                        remain_d = bus.word_cnt;
                        idx_d    = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum_d    = '0;
`endif
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    sum_d = sum_q + bus.byte_in;
`endif
                    // Output word/address are latched only here, so they hold until the next word completes.
                    if (idx_q == 3'd5) begin
                        wr_addr_d = addr_q;
                        wr_data_d = {shift_q, bus.byte_in};
                        idx_d     = '0;
                        state_d   = WRITE;
                    end else begin
                        shift_d = {shift_q[31:0], bus.byte_in};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            WRITE: begin
                addr_d   = addr_q + 16'd1;
                remain_d = remain_q - 14'd1;
                if (remain_q == 14'd1) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (bus.byte_in != sum_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            remain_q  <= '0;
            shift_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            shift_q   <= shift_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign bus.byte_rdy = byte_rdy;
    assign bus.wr_en    = (state_q == WRITE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = err_q;
endmodule
